logc_rr_scheduler: RTL and testbench
====================================

// Module: logc_rr_scheduler
// PURPOSE
//   Shares one log-compression pipeline (preproc -> log_calc -> postproc) between NUM_CH
//   beamformed-envelope channels. Round-robin arbitrates channel samples into the pipeline
//   over valid/ready, tags each issued sample with its channel ID in an in-order tag FIFO,
//   and returns each compressed result with its channel ID. Sits between the envelope
//   detectors and the scan converter.
// PARAMETERS
//   NUM_CH        4   number of requesting channels (>=2)
//   DATA_WIDTH    48  envelope sample width, pipeline input
//   COMP_WIDTH    15  compressed output width, pipeline output
//   MAX_INFLIGHT  8   max samples issued but not yet returned; tag FIFO depth (power of 2)
//   CH_WIDTH      $clog2(NUM_CH)  channel ID width (derived)
// PORTS
//   clk           in   1                   clock, all logic rising-edge
//   reset         in   1                   asynchronous, active-low (0 = in reset)
//   ch_valid      in   NUM_CH              per-channel sample valid
//   ch_data       in   NUM_CH*DATA_WIDTH   per-channel sample, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_ready      out  NUM_CH              per-channel accept, at most one bit high
//   pause         in   1                   stop starting new grants (drain request)
//   lc_in_valid   out  1                   sample valid to pipeline
//   lc_in_ready   in   1                   pipeline accepts sample
//   lc_data       out  DATA_WIDTH          sample to pipeline
//   lc_out_valid  in   1                   pipeline result valid
//   lc_out_ready  out  1                   result accepted from pipeline
//   lc_comp       in   COMP_WIDTH          pipeline compressed result
//   res_valid     out  1                   tagged result valid
//   res_ready     in   1                   downstream accepts result
//   res_data      out  COMP_WIDTH          compressed result
//   res_ch        out  CH_WIDTH            channel ID of res_data
//   inflight      out  $clog2(MAX_INFLIGHT+1)  issued-but-unreturned count
//   idle          out  1                   inflight==0 and lc_in_valid==0
//   err_orphan    out  1                   sticky: result arrived with empty tag FIFO
// BEHAVIOUR
//   Reset (reset=0): rr pointer=0, grant lock clear, tag FIFO empty, inflight=0, err_orphan=0;
//     ch_ready, lc_in_valid, lc_out_ready, res_valid forced 0; idle=1.
//   Issue: eligible = ~pause & (inflight<MAX_INFLIGHT) & |ch_valid. Grant = first ch_valid at or
//     after rr pointer, wrapping NUM_CH-1 -> 0. lc_in_valid=eligible; lc_data=ch_data[grant];
//     ch_ready[grant]=lc_in_ready. Combinational, zero added latency.
//   Handshake fire = lc_in_valid & lc_in_ready: push grant ID to tag FIFO, rr pointer <= grant+1
//     (mod NUM_CH). Pointer unchanged when no fire.
//   Grant lock: if lc_in_valid & ~lc_in_ready, grant and lc_in_valid held next cycle regardless
//     of pause, other ch_valid changes or arbitration; lock clears on fire. Requesters hold
//     ch_valid/ch_data until ch_ready.
//   Return: res_valid=lc_out_valid; res_data=lc_comp; res_ch=FIFO head; lc_out_ready=res_ready.
//     Pop on lc_out_valid & res_ready. Zero added latency, results in issue order.
//   inflight: +1 on fire, -1 on pop, unchanged on both same cycle. At MAX_INFLIGHT no new
//     issue; simultaneous pop at full does not enable issue in the same cycle (registered count).
//   Orphan: lc_out_valid with empty FIFO -> err_orphan<=1 (sticky until reset), res_ch=0,
//     no pop, inflight stays 0.
//   pause: blocks new grants only; in-flight samples still return; idle rises when drained.
//   Reset mid-operation: tags discarded; pipeline shares this reset so no stale results return.
// STRUCTURE
//   logc_pkg: CH_WIDTH/inflight-width functions, default DATA/COMP widths shared with top_logc.
//   Sub-module logc_tag_fifo: synchronous FIFO, width CH_WIDTH, depth MAX_INFLIGHT,
//     push/pop/full/empty/count, same-cycle push+pop legal when non-empty.
//   Arbiter, grant lock and counters in this module.
// TESTING
//   All 4 ch_valid=1, lc_in_ready=1, res_ready=1 -> grants 0,1,2,3,0,...; res_ch matches order.
//   ch_valid=4'b1010, pointer=0 -> grant 1, then 3, then 1; channels 0/2 never ready.
//   lc_in_ready=0 for 3 cycles with ch1 granted, ch0 asserts -> lc_data/grant stay ch1 until fire.
//   res_ready=0, issue 8 samples -> inflight=8, lc_in_valid=0; release one pop -> issue resumes next cycle.
//   pause=1 with 5 in flight -> no new fires, 5 results return with correct res_ch, idle=1 after last.
//   lc_out_valid pulse with empty FIFO -> err_orphan=1 stays until reset=0; reset with 3 in flight -> inflight=0, idle=1.

Source files
------------

// File: rtl/logc_rr_scheduler_pkg.sv
// logc_rr_scheduler_pkg: shared widths and width helpers for the log-compression scheduler
package logc_rr_scheduler_pkg;
  localparam int DEF_DATA_WIDTH = 48;
  localparam int DEF_COMP_WIDTH = 15;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/logc_rr_scheduler_if.sv
// logc_rr_scheduler_if: channel, pipeline, result and status signals of the scheduler
interface logc_rr_scheduler_if
  import logc_rr_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COMP_WIDTH = DEF_COMP_WIDTH,
  parameter int MAX_INFLIGHT = 8
);
  localparam int CH_WIDTH = ch_width(NUM_CH);
  localparam int CNT_WIDTH = cnt_width(MAX_INFLIGHT);
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0] ch_ready;
  logic pause;
  logic lc_in_valid;
  logic lc_in_ready;
  logic [DATA_WIDTH-1:0] lc_data;
  logic lc_out_valid;
  logic lc_out_ready;
  logic [COMP_WIDTH-1:0] lc_comp;
  logic res_valid;
  logic res_ready;
  logic [COMP_WIDTH-1:0] res_data;
  logic [CH_WIDTH-1:0] res_ch;
  logic [CNT_WIDTH-1:0] inflight;
  logic idle;
  logic err_orphan;
  modport slave (
    input ch_valid, ch_data, pause, lc_in_ready, lc_out_valid, lc_comp, res_ready,
    output ch_ready, lc_in_valid, lc_data, lc_out_ready, res_valid, res_data, res_ch,
      inflight, idle, err_orphan
  );
  modport master (
    output ch_valid, ch_data, pause, lc_in_ready, lc_out_valid, lc_comp, res_ready,
    input ch_ready, lc_in_valid, lc_data, lc_out_ready, res_valid, res_data, res_ch,
      inflight, idle, err_orphan
  );
endinterface

// File: rtl/logc_rr_scheduler_tag_fifo.sv
// logc_rr_scheduler_tag_fifo: in-order channel-tag FIFO; push+pop together is legal when non-empty
module logc_rr_scheduler_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CNT_WIDTH'(DEPTH);
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= push_data_i;
endmodule

// File: rtl/logc_rr_scheduler.sv
// logc_rr_scheduler: round-robin shares one log-compression pipeline between channels,
// tagging each issued sample so results come back labelled with their channel.
module logc_rr_scheduler
  import logc_rr_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COMP_WIDTH = DEF_COMP_WIDTH,
  parameter int MAX_INFLIGHT = 8
) (
  input logic clk,
  input logic reset,
  logc_rr_scheduler_if.slave bus
);
  localparam int CH_WIDTH = ch_width(NUM_CH);
  localparam int CNT_WIDTH = cnt_width(MAX_INFLIGHT);
  logic [CH_WIDTH-1:0] ptr_q, ptr_d, lock_ch_q, arb, grant, head;
  logic [CNT_WIDTH-1:0] count;
  logic lock_q, found, fire, pop, empty, full, err_q;
  always_comb begin
    arb = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && bus.ch_valid[(int'(ptr_q) + k) % NUM_CH]) begin
        arb = CH_WIDTH'((int'(ptr_q) + k) % NUM_CH);
        found = 1'b1;
      end
    end
  end
  // A stalled offer stays locked on its channel until the pipeline takes it
  assign grant = lock_q ? lock_ch_q : arb;
  assign bus.lc_in_valid = reset & (lock_q | (~bus.pause & ~full & found));
  assign bus.lc_data = bus.ch_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign fire = bus.lc_in_valid & bus.lc_in_ready;
  assign bus.ch_ready = fire ? NUM_CH'(1) << grant : '0;
  assign ptr_d = fire ? ((grant == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant + 1'b1) : ptr_q;
  assign pop = bus.lc_out_valid & bus.res_ready & ~empty;
  assign bus.res_valid = reset & bus.lc_out_valid;
  assign bus.res_data = bus.lc_comp;
  assign bus.res_ch = empty ? '0 : head;
  assign bus.lc_out_ready = reset & bus.res_ready;
  assign bus.inflight = count;
  assign bus.idle = (count == '0) & ~bus.lc_in_valid;
  assign bus.err_orphan = err_q;
  logc_rr_scheduler_tag_fifo #(
    .WIDTH(CH_WIDTH),
    .DEPTH(MAX_INFLIGHT),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_tags (
    .clk(clk),
    .reset(reset),
    .push_i(fire),
    .push_data_i(grant),
    .pop_i(pop),
    .head_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr_q <= '0;
      lock_q <= 1'b0;
      lock_ch_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      lock_q <= bus.lc_in_valid & ~bus.lc_in_ready;
      lock_ch_q <= grant;
      err_q <= err_q | (bus.lc_out_valid & empty);
    end
endmodule

// File: tb/tb_logc_rr_scheduler.sv
// tb_logc_rr_scheduler: directed vector table plus hand sequences for lock, full, drain, orphan, reset
module tb_logc_rr_scheduler;
  localparam int N = 4, DW = 48, CW = 15, MI = 8;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logc_rr_scheduler_if #(.NUM_CH(N), .DATA_WIDTH(DW), .COMP_WIDTH(CW), .MAX_INFLIGHT(MI)) bus();
  logc_rr_scheduler #(.NUM_CH(N), .DATA_WIDTH(DW), .COMP_WIDTH(CW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [3:0] cv;
    logic ps, ir, ov, rr;
    logic [3:0] rdy;
    logic iv;
    int g;
    logic rv;
    int rch;
    int inf;
    logic idl;
  } vec_t;
  vec_t tv[16];
  function automatic logic [63:0] dat(input int ch);
    return 64'h0000_CAFE_0000_0000 + 64'(ch);
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic rst();
    bus.ch_valid = '0;
    bus.pause = 1'b0;
    bus.lc_in_ready = 1'b1;
    bus.lc_out_valid = 1'b0;
    bus.res_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    tv[0]  = '{4'hF, 0, 1, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0};
    tv[1]  = '{4'hF, 0, 1, 1, 1, 4'b0010, 1, 1, 1, 0, 1, 0};
    tv[2]  = '{4'hF, 0, 1, 1, 1, 4'b0100, 1, 2, 1, 1, 1, 0};
    tv[3]  = '{4'hF, 0, 1, 0, 1, 4'b1000, 1, 3, 0, 0, 1, 0};
    tv[4]  = '{4'hA, 0, 1, 1, 1, 4'b0010, 1, 1, 1, 2, 2, 0};
    tv[5]  = '{4'hA, 0, 1, 1, 1, 4'b1000, 1, 3, 1, 3, 2, 0};
    tv[6]  = '{4'hA, 0, 1, 0, 1, 4'b0010, 1, 1, 0, 0, 2, 0};
    tv[7]  = '{4'h0, 0, 1, 1, 1, 4'b0000, 0, 0, 1, 1, 3, 0};
    tv[8]  = '{4'hF, 1, 1, 1, 1, 4'b0000, 0, 0, 1, 3, 2, 0};
    tv[9]  = '{4'hF, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 1, 1, 0};
    tv[10] = '{4'hF, 1, 1, 1, 1, 4'b0000, 0, 0, 1, 1, 1, 0};
    tv[11] = '{4'h0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 1};
    tv[12] = '{4'h1, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 0, 0, 0};
    tv[13] = '{4'h3, 1, 0, 0, 1, 4'b0000, 1, 0, 0, 0, 0, 0};
    tv[14] = '{4'h3, 1, 1, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0};
    tv[15] = '{4'h3, 1, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < N; i++) bus.ch_data[i*DW +: DW] = DW'(dat(i));
    bus.lc_comp = '0;
    reset = 1'b0;
    bus.ch_valid = '1;
    bus.pause = 1'b0;
    bus.lc_in_ready = 1'b1;
    bus.lc_out_valid = 1'b1;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset lc_in_valid", 64'(bus.lc_in_valid), 0);
    chk("reset ch_ready", 64'(bus.ch_ready), 0);
    chk("reset res_valid", 64'(bus.res_valid), 0);
    chk("reset lc_out_ready", 64'(bus.lc_out_ready), 0);
    chk("reset idle", 64'(bus.idle), 1);
    chk("reset inflight", 64'(bus.inflight), 0);
    chk("reset err_orphan", 64'(bus.err_orphan), 0);
    rst();
    for (int i = 0; i < 16; i++) begin
      bus.ch_valid = tv[i].cv;
      bus.pause = tv[i].ps;
      bus.lc_in_ready = tv[i].ir;
      bus.lc_out_valid = tv[i].ov;
      bus.res_ready = tv[i].rr;
      bus.lc_comp = CW'(16'h100 + i);
      #1;
      chk($sformatf("row%0d ch_ready", i), 64'(bus.ch_ready), 64'(tv[i].rdy));
      chk($sformatf("row%0d lc_in_valid", i), 64'(bus.lc_in_valid), 64'(tv[i].iv));
      if (tv[i].iv) chk($sformatf("row%0d lc_data", i), 64'(bus.lc_data), dat(tv[i].g));
      chk($sformatf("row%0d res_valid", i), 64'(bus.res_valid), 64'(tv[i].rv));
      if (tv[i].rv) begin
        chk($sformatf("row%0d res_ch", i), 64'(bus.res_ch), 64'(tv[i].rch));
        chk($sformatf("row%0d res_data", i), 64'(bus.res_data), 64'(16'h100 + i));
      end
      chk($sformatf("row%0d inflight", i), 64'(bus.inflight), 64'(tv[i].inf));
      chk($sformatf("row%0d idle", i), 64'(bus.idle), 64'(tv[i].idl));
      @(negedge clk);
    end
    rst();
    bus.ch_valid = 4'b0010;
    bus.lc_in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) bus.ch_valid = 4'b0011;
      #1;
      chk($sformatf("lock%0d lc_data", k), 64'(bus.lc_data), dat(1));
      chk($sformatf("lock%0d ch_ready", k), 64'(bus.ch_ready), 0);
      chk($sformatf("lock%0d lc_in_valid", k), 64'(bus.lc_in_valid), 1);
      @(negedge clk);
    end
    bus.lc_in_ready = 1'b1;
    #1;
    chk("lock fire ch_ready", 64'(bus.ch_ready), 64'(4'b0010));
    chk("lock fire lc_data", 64'(bus.lc_data), dat(1));
    @(negedge clk);
    bus.ch_valid = 4'b0001;
    #1;
    chk("after lock ch_ready", 64'(bus.ch_ready), 64'(4'b0001));
    chk("after lock inflight", 64'(bus.inflight), 1);
    rst();
    bus.ch_valid = 4'hF;
    bus.res_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("full inflight", 64'(bus.inflight), 8);
    chk("full lc_in_valid", 64'(bus.lc_in_valid), 0);
    chk("full ch_ready", 64'(bus.ch_ready), 0);
    bus.lc_out_valid = 1'b1;
    bus.res_ready = 1'b1;
    bus.lc_comp = 15'h1234;
    #1;
    chk("full pop lc_in_valid", 64'(bus.lc_in_valid), 0);
    chk("full pop res_ch", 64'(bus.res_ch), 0);
    chk("full pop res_data", 64'(bus.res_data), 64'h1234);
    @(negedge clk);
    bus.lc_out_valid = 1'b0;
    #1;
    chk("resume inflight", 64'(bus.inflight), 7);
    chk("resume lc_in_valid", 64'(bus.lc_in_valid), 1);
    chk("resume ch_ready", 64'(bus.ch_ready), 64'(4'b0001));
    rst();
    bus.ch_valid = 4'hF;
    repeat (5) @(negedge clk);
    bus.pause = 1'b1;
    bus.lc_out_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("drain%0d res_ch", k), 64'(bus.res_ch), 64'(k % 4));
      chk($sformatf("drain%0d lc_in_valid", k), 64'(bus.lc_in_valid), 0);
      chk($sformatf("drain%0d inflight", k), 64'(bus.inflight), 64'(5 - k));
      @(negedge clk);
    end
    bus.lc_out_valid = 1'b0;
    #1;
    chk("drained idle", 64'(bus.idle), 1);
    chk("drained inflight", 64'(bus.inflight), 0);
    @(negedge clk);
    bus.lc_out_valid = 1'b1;
    #1;
    chk("orphan res_ch", 64'(bus.res_ch), 0);
    chk("orphan err before edge", 64'(bus.err_orphan), 0);
    @(negedge clk);
    bus.lc_out_valid = 1'b0;
    #1;
    chk("orphan err", 64'(bus.err_orphan), 1);
    chk("orphan inflight", 64'(bus.inflight), 0);
    repeat (3) @(negedge clk);
    chk("orphan err sticky", 64'(bus.err_orphan), 1);
    bus.pause = 1'b0;
    repeat (3) @(negedge clk);
    bus.pause = 1'b1;
    #1;
    chk("pre-reset inflight", 64'(bus.inflight), 3);
    bus.pause = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid reset inflight", 64'(bus.inflight), 0);
    chk("mid reset idle", 64'(bus.idle), 1);
    chk("mid reset lc_in_valid", 64'(bus.lc_in_valid), 0);
    chk("mid reset ch_ready", 64'(bus.ch_ready), 0);
    chk("mid reset err_orphan", 64'(bus.err_orphan), 0);
    @(negedge clk);
    bus.ch_valid = '0;
    reset = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
